bcd_digit_feeder: RTL and testbench

BCD_DIGIT_FEEDER -- requirements
Module: bcd_digit_feeder

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_step_div.sv | 38 +++
 rtl/bcd_digit_feeder.sv | 111 +++++++++++
 tb/tb_bcd_digit_feeder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD digit feeder.
package bcd_pkg;

  localparam int unsigned BCD_MAX = 9;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Next digit one step away in the given direction, wrapping in 0..max_d.
  function automatic digit_t step_digit(input digit_t d, input logic up, input digit_t max_d);
    if (up) step_digit = (d == max_d) ? '0 : d + 4'd1;
    else    step_digit = (d == '0) ? max_d : d - 4'd1;
  endfunction

  // True when a step from d in the given direction crosses the decade boundary.
  function automatic logic step_wraps(input digit_t d, input logic up, input digit_t max_d);
    step_wraps = up ? (d == max_d) : (d == '0);
  endfunction

endpackage

// File: rtl/bcd_step_div.sv
// Step divider: counts enabled cycles 0..STEP_DIV-1 and ticks on the last one.
module bcd_step_div
  import bcd_pkg::*;
#(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic freeze,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = en && !freeze && !clr && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap only when enabled and not frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !freeze) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 8'd1;
    end
  end

  // Divider count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_digit_feeder.sv
// Decade up/down digit source with load, handshake to a segment decoder,
// wrap carry and sticky illegal-load flag.
module bcd_digit_feeder
  import bcd_pkg::*;
#(
  parameter int unsigned STEP_DIV  = 4,
  parameter int unsigned MAX_DIGIT = BCD_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       carry,
  output logic       err
);

  localparam digit_t MAX_D = digit_t'(MAX_DIGIT);

  state_e state_q, state_d;
  digit_t digit_q, digit_d;
  logic   carry_q, carry_d;
  logic   err_q, err_d;

  logic load_ok;
  logic load_bad;
  logic div_clr;
  logic div_freeze;
  logic tick;

  assign load_ok  = load && (load_val <= MAX_D);
  assign load_bad = load && (load_val > MAX_D);

  // An illegal load freezes the divider too, so that cycle is a no-op apart from err.
  assign div_freeze = (state_q == HOLD) || load_bad;

  bcd_step_div #(
    .STEP_DIV(STEP_DIV)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (div_clr),
    .freeze(div_freeze),
    .tick  (tick)
  );

  // Next-state, digit, carry and error logic; loads take precedence over steps and handshakes.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    carry_d = 1'b0;
    err_d   = err_q;
    div_clr = 1'b0;
    if (load_bad) begin
      err_d = 1'b1;
    end else if (load_ok) begin
      digit_d = load_val;
      div_clr = 1'b1;
      state_d = HOLD;
    end else begin
      unique case (state_q)
        // The divider counts in IDLE as well, so a retained count can tick on the first
        // enabled cycle after a pause.
        IDLE, RUN: begin
          if (tick) begin
            digit_d = step_digit(digit_q, up, MAX_D);
            carry_d = step_wraps(digit_q, up, MAX_D);
            state_d = HOLD;
          end else if (en) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (out_ready) state_d = en ? RUN : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, digit, carry and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      digit_q <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign out_valid             = (state_q == HOLD);
  assign {in1, in2, in3, in4}  = digit_q;
  assign carry                 = carry_q;
  assign err                   = err_q;

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Directed self-checking bench for bcd_digit_feeder (STEP_DIV=4, MAX_DIGIT=9).
module tb_bcd_digit_feeder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       out_ready;
  logic       out_valid;
  logic       in1, in2, in3, in4;
  logic       carry;
  logic       err;

  int unsigned checks;
  int unsigned errors;

  bcd_digit_feeder #(
    .STEP_DIV (4),
    .MAX_DIGIT(9)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .carry    (carry),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock, then settle 1 time unit past the edge for driving and sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] dig();
    return {in1, in2, in3, in4};
  endfunction

  // From a presented digit with out_ready=1: handshake, 3 quiet cycles, then new digit.
  task automatic next_dig(input string tag, input logic [3:0] exp_d, input logic exp_c);
    cyc();
    chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_hs_carry"}, 32'(carry), 32'd0);
    repeat (3) cyc();
    chk({tag, "_gap_valid"}, 32'(out_valid), 32'd0);
    cyc();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_digit"}, 32'(dig()), 32'(exp_d));
    chk({tag, "_carry"}, 32'(carry), 32'(exp_c));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; out_ready = 1'b0;
    #1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_digit", 32'(dig()), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Up-count from reset: first digit after 4 enabled cycles, then every 5.
    en = 1'b1; up = 1'b1; out_ready = 1'b1;
    repeat (3) cyc();
    chk("up1_early_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("up1_valid", 32'(out_valid), 32'd1);
    chk("up1_digit", 32'(dig()), 32'd1);
    chk("up1_carry", 32'(carry), 32'd0);
    for (int k = 2; k <= 10; k++) begin
      next_dig($sformatf("up%0d", k), 4'(k % 10), (k == 10));
    end

    // Backpressure: load 3 in HOLD (no valid gap), hold 20 cycles, then next is 4.
    out_ready = 1'b0; load = 1'b1; load_val = 4'd3;
    cyc();
    load = 1'b0;
    chk("bp_load_valid", 32'(out_valid), 32'd1);
    chk("bp_load_digit", 32'(dig()), 32'd3);
    chk("bp_load_carry", 32'(carry), 32'd0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_digit", i), 32'(dig()), 32'd3);
    end
    out_ready = 1'b1;
    next_dig("bp_next", 4'd4, 1'b0);

    // Down wrap: load 0 coinciding with a handshake, then 9 with carry, then 8.
    up = 1'b0; load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0;
    chk("dn_load_valid", 32'(out_valid), 32'd1);
    chk("dn_load_digit", 32'(dig()), 32'd0);
    next_dig("dn9", 4'd9, 1'b1);
    next_dig("dn8", 4'd8, 1'b0);

    // Illegal load: digit and pending state untouched, err sticks through counting.
    load = 1'b1; load_val = 4'd12;
    cyc();
    load = 1'b0;
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_digit", 32'(dig()), 32'd8);
    chk("ill_err", 32'(err), 32'd1);
    up = 1'b1;
    next_dig("ill_up9", 4'd9, 1'b0);
    next_dig("ill_up0", 4'd0, 1'b1);
    chk("ill_err_sticky", 32'(err), 32'd1);

    // Load/step collision: load 7 on the cycle that would step 2 -> 3.
    load = 1'b1; load_val = 4'd2;
    cyc();
    load = 1'b0;
    chk("col_pre_digit", 32'(dig()), 32'd2);
    cyc();
    chk("col_hs_valid", 32'(out_valid), 32'd0);
    repeat (3) cyc();
    load = 1'b1; load_val = 4'd7;
    cyc();
    load = 1'b0;
    chk("col_valid", 32'(out_valid), 32'd1);
    chk("col_digit", 32'(dig()), 32'd7);
    chk("col_carry", 32'(carry), 32'd0);

    // Reset while 5 is pending, with competing load and out_ready.
    out_ready = 1'b0; load = 1'b1; load_val = 4'd5;
    cyc();
    load = 1'b0;
    chk("rh_pre_digit", 32'(dig()), 32'd5);
    chk("rh_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; en = 1'b0; load = 1'b1; load_val = 4'd6; out_ready = 1'b1;
    cyc();
    rst = 1'b0; load = 1'b0;
    chk("rh_valid", 32'(out_valid), 32'd0);
    chk("rh_digit", 32'(dig()), 32'd0);
    chk("rh_err", 32'(err), 32'd0);
    chk("rh_carry", 32'(carry), 32'd0);
    repeat (3) cyc();
    chk("rh_idle_valid", 32'(out_valid), 32'd0);
    en = 1'b1;
    repeat (3) cyc();
    chk("rh_run_early", 32'(out_valid), 32'd0);
    cyc();
    chk("rh_first_valid", 32'(out_valid), 32'd1);
    chk("rh_first_digit", 32'(dig()), 32'd1);

    // Enable pause in RUN: divider count is retained across the pause.
    cyc();
    chk("pause_hs_valid", 32'(out_valid), 32'd0);
    cyc(); cyc();
    en = 1'b0;
    repeat (5) cyc();
    chk("pause_valid", 32'(out_valid), 32'd0);
    en = 1'b1;
    cyc();
    chk("pause_resume_early", 32'(out_valid), 32'd0);
    cyc();
    chk("pause_resume_valid", 32'(out_valid), 32'd1);
    chk("pause_resume_digit", 32'(dig()), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
